// File: rtl/cpu_trace_capture.sv
// Trace sink for the CPU observation outputs: captures {OP, PC, ALU} whenever the PC
// changes, queues records in a FIFO and streams each one out as a 9-byte frame.
module cpu_trace_capture #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      PCIN,
  input  logic [31:0]      ALUIN,
  input  logic [5:0]       OPIN,
  input  logic             CaptureEn,
  input  logic             TxReady,
  output logic             TxValid,
  output logic [7:0]       TxByte,
  output logic [CNT_W-1:0] Count,
  output logic             Overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int REC_W   = 70;
  localparam int FRAME_W = 72;
  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [31:0]        last_pc_q, last_pc_d;
  logic               have_last_q, have_last_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [REC_W-1:0]   fifo_mem [DEPTH];
  logic [REC_W-1:0]   rec_in;
  logic [REC_W-1:0]   rec_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               capture;
  logic               push;
  logic               pop;
  logic               drop;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [REC_W-1:0] rec);
    return {2'b00, rec};
  endfunction

  assign rec_in     = {OPIN, PCIN, ALUIN};
  assign rec_head   = fifo_mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign capture    = CaptureEn && (!have_last_q || (PCIN != last_pc_q));

  // Serializer: a pop on the last-byte transfer chains frames with no TxValid gap
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = build_frame(rec_head);
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (TxReady) begin
          if (idx_q != LAST_IDX) begin
            shreg_d = {shreg_q[FRAME_W-9:0], 8'h00};
            idx_d   = idx_q + 4'd1;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = build_frame(rec_head);
            idx_d   = 4'd0;
          end else begin
            shreg_d = '0;
            idx_d   = 4'd0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // A full FIFO still accepts a record when the serializer pops on the same edge
  always_comb begin
    push        = capture && (!fifo_full || pop);
    drop        = capture && fifo_full && !pop;
    last_pc_d   = capture ? PCIN : last_pc_q;
    have_last_d = have_last_q | capture;
    overflow_d  = overflow_q | drop;
    wr_ptr_d    = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d    = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      shreg_q     <= '0;
      last_pc_q   <= 32'd0;
      have_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage carries no reset; the pointers and count define what is valid
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= rec_in;
    end
  end

  assign TxValid  = (state_q == SEND);
  assign TxByte   = shreg_q[FRAME_W-1:FRAME_W-8];
  assign Count    = count_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: directed captures push expected bytes,
// a negedge monitor pops and compares on every TxValid&&TxReady handshake.
module tb_cpu_trace_capture;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCIN;
  logic [31:0] ALUIN;
  logic [5:0]  OPIN;
  logic        CaptureEn;
  logic        TxReady;
  logic        TxValid;
  logic [7:0]  TxByte;
  logic [4:0]  Count;
  logic        Overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       mon_hold;
  logic [7:0] hold_byte;
  logic [7:0] exp_b;

  cpu_trace_capture #(.DEPTH(16), .CNT_W(5)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PCIN     (PCIN),
    .ALUIN    (ALUIN),
    .OPIN     (OPIN),
    .CaptureEn(CaptureEn),
    .TxReady  (TxReady),
    .TxValid  (TxValid),
    .TxByte   (TxByte),
    .Count    (Count),
    .Overflow (Overflow)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] alu);
    exp_q.push_back({2'b00, op});
    for (int i = 3; i >= 0; i--) exp_q.push_back(pc[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(alu[i*8 +: 8]);
  endtask

  // Monitor: handshake at the coming edge consumes one expected byte; a stall must hold
  initial begin
    mon_hold  = 1'b0;
    hold_byte = 8'h00;
    forever begin
      @(negedge Clk);
      if (mon_hold) begin
        check("hold_valid", 32'(TxValid), 32'd1);
        check("hold_byte", 32'(TxByte), 32'(hold_byte));
      end
      if (!Reset && TxValid && TxReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h required no byte", TxByte);
        end else begin
          exp_b = exp_q.pop_front();
          check("stream_byte", 32'(TxByte), 32'(exp_b));
        end
      end
      mon_hold  = !Reset && TxValid && !TxReady;
      hold_byte = TxByte;
    end
  end

  initial begin
    int vcnt;
    int rises;
    int maxcnt;
    logic prevv;

    Reset = 1'b1; PCIN = 32'd0; ALUIN = 32'd0; OPIN = 6'd0;
    CaptureEn = 1'b0; TxReady = 1'b0;

    // Test 1: reset state, single frame, first-valid latency
    repeat (10) tick();
    check("rst_txvalid", 32'(TxValid), 32'd0);
    check("rst_txbyte", 32'(TxByte), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    Reset = 1'b0; CaptureEn = 1'b1; PCIN = 32'h0000_0004; ALUIN = 32'h0000_002A;
    OPIN = 6'h23; TxReady = 1'b1;
    exp_q.push_back(8'h23); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h2A);
    tick();
    check("t1_valid_at_capture", 32'(TxValid), 32'd0);
    check("t1_count_at_capture", 32'(Count), 32'd1);
    tick();
    check("t1_valid_next", 32'(TxValid), 32'd1);
    check("t1_byte0", 32'(TxByte), 32'h23);
    check("t1_count_next", 32'(Count), 32'd0);
    repeat (15) tick();
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_no_second_frame", 32'(TxValid), 32'd0);

    // Test 2: four consecutive PCs -> back-to-back frames
    for (int k = 0; k < 4; k++)
      push_frame(6'(16 + k), 32'(4 * k), 32'hA0B0_C000 + 32'(k));
    PCIN = 32'd0; ALUIN = 32'hA0B0_C000; OPIN = 6'h10;
    tick();
    vcnt = 0; rises = 0; maxcnt = 0; prevv = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i < 3) begin
        PCIN  = 32'(4 * (i + 1));
        ALUIN = 32'hA0B0_C000 + 32'(i + 1);
        OPIN  = 6'(17 + i);
      end
      tick();
      if (TxValid) vcnt++;
      if (TxValid && !prevv) rises++;
      prevv = TxValid;
      if (int'(Count) > maxcnt) maxcnt = int'(Count);
      if (i == 2) check("t2_count_after_4th", 32'(Count), 32'd3);
    end
    check("t2_valid_cycles", 32'(vcnt), 32'd36);
    check("t2_valid_runs", 32'(rises), 32'd1);
    check("t2_count_peak", 32'(maxcnt), 32'd3);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Test 3: stalled sink, 20 captures -> full FIFO and overflow
    TxReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      PCIN  = 32'h0000_0100 + 32'(4 * k);
      ALUIN = 32'h5500_0000 | 32'(k);
      OPIN  = 6'(k + 1);
      if (k <= 16) push_frame(OPIN, PCIN, ALUIN);
      tick();
    end
    check("t3_count_full", 32'(Count), 32'd16);
    check("t3_overflow", 32'(Overflow), 32'd1);
    check("t3_stall_valid", 32'(TxValid), 32'd1);
    check("t3_stall_byte0", 32'(TxByte), 32'h01);
    TxReady = 1'b1;
    repeat (170) tick();
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_count_empty", 32'(Count), 32'd0);
    check("t3_idle", 32'(TxValid), 32'd0);
    check("t3_overflow_sticky", 32'(Overflow), 32'd1);

    // Test 4: TxReady toggling during a frame
    TxReady = 1'b0; PCIN = 32'h0000_0004; ALUIN = 32'h0000_002A; OPIN = 6'h23;
    exp_q.push_back(8'h23); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h2A);
    for (int i = 0; i < 30; i++) begin
      tick();
      TxReady = ~TxReady;
    end
    TxReady = 1'b1;
    repeat (5) tick();
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_idle", 32'(TxValid), 32'd0);

    // Test 5: reset at byte 4 with three records queued
    exp_q.push_back(8'h31); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    for (int k = 0; k < 4; k++) begin
      PCIN  = 32'h1122_3344 + 32'(4 * k);
      ALUIN = 32'hDEAD_0000 + 32'(k);
      OPIN  = 6'(49 + k);
      tick();
    end
    repeat (2) tick();
    check("t5_at_byte4", 32'(TxByte), 32'h44);
    check("t5_queued", 32'(Count), 32'd3);
    Reset = 1'b1;
    tick();
    Reset = 1'b0; CaptureEn = 1'b0;
    check("t5_rst_valid", 32'(TxValid), 32'd0);
    check("t5_rst_count", 32'(Count), 32'd0);
    check("t5_rst_overflow", 32'(Overflow), 32'd0);
    check("t5_rst_byte", 32'(TxByte), 32'd0);
    check("t5_partial_consumed", 32'(exp_q.size()), 32'd0);
    repeat (5) tick();
    check("t5_silent_after_rst", 32'(TxValid), 32'd0);
    push_frame(6'h34, 32'h1122_3350, 32'hDEAD_0003);
    CaptureEn = 1'b1;
    tick();
    tick();
    check("t5_fresh_valid", 32'(TxValid), 32'd1);
    check("t5_fresh_byte0", 32'(TxByte), 32'h34);
    repeat (15) tick();
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_idle", 32'(TxValid), 32'd0);

    // Test 6: capture while full, coinciding with the last-byte pop
    TxReady = 1'b0;
    for (int k = 0; k < 17; k++) begin
      PCIN  = 32'h3000_0000 + 32'(4 * k);
      ALUIN = 32'h7700_0000 + 32'(17 * (k + 1));
      OPIN  = 6'(k + 20);
      push_frame(OPIN, PCIN, ALUIN);
      tick();
    end
    check("t6_count_full", 32'(Count), 32'd16);
    check("t6_no_overflow_yet", 32'(Overflow), 32'd0);
    TxReady = 1'b1;
    repeat (8) tick();
    check("t6_at_byte8", 32'(TxByte), 32'h11);
    PCIN = 32'h3000_0100; ALUIN = 32'h1234_5678; OPIN = 6'h3F;
    push_frame(OPIN, PCIN, ALUIN);
    tick();
    check("t6_count_holds", 32'(Count), 32'd16);
    check("t6_overflow_clear", 32'(Overflow), 32'd0);
    check("t6_valid_no_gap", 32'(TxValid), 32'd1);
    check("t6_next_byte0", 32'(TxByte), 32'h15);
    repeat (180) tick();
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_count_empty", 32'(Count), 32'd0);
    check("t6_overflow_final", 32'(Overflow), 32'd0);
    check("t6_idle", 32'(TxValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trace_capture.md
Name: cpu_trace_capture

Overview:
Sink-side companion to the CPU's observation outputs (PCOUT, ALUOUT, CURROP).
- Samples one trace record each time the CPU's PC changes, buffers records in a FIFO, and serializes each record as 9 bytes over a valid/ready byte stream to a UART/debug link.
- Sits beside the CPU at top level; on the bench it lets a program's execution be checked from the byte stream alone.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
CNT_W, 5, width of Count; equals log2(DEPTH)+1

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
PCIN  input  32  CPU program counter (PCOUT)
ALUIN  input  32  CPU ALU result (ALUOUT)
OPIN  input  6  CPU current opcode (CURROP)
CaptureEn  input  1  enables record capture
TxReady  input  1  downstream accepts TxByte this cycle
TxValid  output  1  TxByte holds a valid byte
TxByte  output  8  serialized trace byte
Count  output  CNT_W  records held in the FIFO; excludes the record being serialized
Overflow  output  1  sticky: a record was dropped because the FIFO was full

Behaviour:
- One clock domain. Reset is synchronous and active-high; both are fixed.
- Reset is sampled at the Clk edge. After that edge:
  - TxValid=0, TxByte=0, Count=0, Overflow=0.
  - FIFO is empty, the serializer is IDLE, HaveLast=0, LastPC=0.
- Capture condition, evaluated at each edge: CaptureEn=1 AND (HaveLast=0 OR PCIN!=LastPC).
- When the condition holds at an edge:
  - LastPC<=PCIN and HaveLast<=1.
  - Record {OPIN, PCIN, ALUIN} is pushed, unless the FIFO is full and no pop occurs that edge.
  - A dropped record sets Overflow<=1. Overflow holds until Reset.
  - LastPC updates even when the record is dropped.
- CaptureEn=0: nothing captured; LastPC and HaveLast are held.
- Push and pop on the same edge: both take effect. Count is unchanged. A push while full succeeds if a pop occurs that edge.
- Frame format, 9 bytes, in this order:
  - byte0 = {2'b00, OP}
  - bytes1-4 = PC[31:24], PC[23:16], PC[15:8], PC[7:0]
  - bytes5-8 = ALU[31:24] down to ALU[7:0]
- Serializer states are IDLE and SEND, with byte index Idx from 0 to 8.
  - IDLE, FIFO non-empty at an edge: pop the head into the 72-bit shift register, Idx<=0, go to SEND. TxValid=1 with byte0 after that edge.
  - SEND: a transfer occurs at an edge where TxValid=1 and TxReady=1.
  - SEND, transfer with Idx<8: shift to the next byte, Idx<=Idx+1.
  - SEND, transfer with Idx=8 and FIFO non-empty: pop the next record, Idx<=0, stay in SEND. Back-to-back frames have no TxValid gap.
  - SEND, transfer with Idx=8 and FIFO empty: go to IDLE, TxValid<=0.
  - SEND, TxReady=0: TxByte, TxValid and Idx hold. TxValid never drops mid-frame except on Reset.
- Latency: a record captured at edge E produces TxValid=1 after edge E+1, provided the serializer was IDLE.
- Count: registered; reflects the pushes and pops of the previous edge. Range 0..DEPTH.
- FIFO: circular, with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Reset mid-frame: the partial frame is abandoned and FIFO contents are discarded. No further bytes are emitted until a new capture.

Test Plan:
1. Reset=1 for 10 cycles, then CaptureEn=1, PCIN=0x00000004, ALUIN=0x0000002A, OPIN=6'h23, TxReady=1.
   -> One frame: 23 00 00 00 04 00 00 00 2A. TxValid is first high one cycle after the capture edge. PC held constant, so no second frame.
2. PCIN steps 0,4,8,0xC on consecutive cycles, TxReady=1.
   -> 4 frames back-to-back, 36 consecutive TxValid cycles, PCs in order. Count peaks at 3.
3. TxReady=0 while 20 distinct PCs are captured (DEPTH=16).
   -> Count saturates at 16, Overflow=1, TxByte stalls at byte0 of PC#0. After TxReady=1, 17 frames arrive (1 in serializer + 16 FIFO): PC#0..PC#16. PC#17..PC#19 are absent.
4. TxReady toggles 1,0,1,0 during a frame.
   -> TxByte is stable while TxReady=0. The byte sequence matches test 1 with no duplicates or skips.
5. Reset asserted for 1 cycle at byte 4 of a frame, with 3 records queued.
   -> After that edge TxValid=0, Count=0, Overflow=0. The next capture of the same PC emits a fresh frame, since HaveLast was cleared.
6. Capture while full with a simultaneous pop (Idx=8 transfer on the same edge).
   -> Record accepted, Count stays 16, Overflow stays 0.
